// File: rtl/sense_poll_scheduler.sv
// sense_poll_scheduler: sequences temperature-sensor reads on the Tempsens board.
//   - Divides clk into a one-cycle serial-rate enable (tick_en); no derived clock.
//   - Arbitrates a periodic poll timer against host one-shot read requests
//     (round-robin when both are pending) and runs one read at a time.
//   - Handles reader completion, tick-based timeout and result delivery.
// Optional build macro: SENSE_OVERRUN_CNT_EN adds the 8-bit overrun_cnt output,
// a saturating count of poll events that collapsed into an already-pending poll.
`timescale 1ns/1ps

module sense_poll_scheduler #(
  parameter int DIV_COUNT     = 135000, // tick_en every DIV_COUNT+1 clocks
  parameter int POLL_TICKS    = 270000, // ticks between periodic polls (>= 2)
  parameter int TIMEOUT_TICKS = 64,     // ticks in WAIT before abort (>= 1)
  parameter int DATA_W        = 16      // sensor sample width
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              host_req,
  output logic              host_ack,
  output logic              rd_start,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tick_en,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              sample_src,
  output logic              timeout_err,
  input  logic              err_clr
`ifdef SENSE_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  // Counter widths; each counter only ever needs to hold its terminal value.
  localparam int DIV_W  = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
  localparam int POLL_W = $clog2(POLL_TICKS);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_COUNT);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Source encoding doubles as the sample_src output value.
  typedef enum logic {
    SRC_POLL = 1'b0,
    SRC_HOST = 1'b1
  } src_t;

  state_t             state;
  state_t             state_nxt;
  src_t               last_grant;
  src_t               grant_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               poll_pending;
  logic               poll_event;
  logic               host_active;
  logic               host_pending;
  logic               to_fire;
  logic               txn_end;
  logic               poll_clear;

  // ---------------------------------------------------------------------------
  // Serial-rate enable: free-running divider, independent of enable.
  // ---------------------------------------------------------------------------
  assign tick_en = (div_cnt == DIV_LAST);

  // Divider counts 0..DIV_COUNT and wraps on the tick cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        div_cnt <= '0;
    else if (tick_en) div_cnt <= '0;
    else              div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Periodic poll timer and pending bit.
  // ---------------------------------------------------------------------------
  // A poll event is the tick on which the timer sits at its last value.
  assign poll_event = enable & tick_en & (poll_cnt == POLL_LAST);

  // Poll timer advances on tick_en while enabled, held at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        poll_cnt <= '0;
    else if (!enable) poll_cnt <= '0;
    else if (tick_en) poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + POLL_W'(1);
  end

  // A transaction ends either in DONE or on the timeout-abort cycle in WAIT.
  assign txn_end    = (state == S_DONE) | to_fire;
  assign poll_clear = txn_end & (last_grant == SRC_POLL);

  // Pending poll: set by a poll event (set beats clear), cleared when the poll
  // transaction ends or when the scheduler is disabled. A poll event arriving
  // while the bit is already set simply collapses into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           poll_pending <= 1'b0;
    else if (!enable)    poll_pending <= 1'b0;
    else if (poll_event) poll_pending <= 1'b1;
    else if (poll_clear) poll_pending <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Host request: level input, pending only while enabled and not being served.
  // ---------------------------------------------------------------------------
  assign host_active  = (state != S_IDLE) & (last_grant == SRC_HOST);
  assign host_pending = host_req & enable & ~host_active;

  // ---------------------------------------------------------------------------
  // Timeout: counts tick_en while waiting; the abort fires on the tick that
  // brings the count to TIMEOUT_TICKS. A coincident rd_done wins.
  // ---------------------------------------------------------------------------
  assign to_fire = (state == S_WAIT) & ~rd_done & tick_en & (to_cnt == TO_LAST);

  // Timeout counter cleared in START, stepped on ticks while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       to_cnt <= '0;
    else if (state == S_START)                       to_cnt <= '0;
    else if ((state == S_WAIT) && tick_en && !rd_done) to_cnt <= to_cnt + TO_W'(1);
  end

  // Sticky timeout flag; a new timeout beats a same-cycle err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        timeout_err <= 1'b0;
    else if (to_fire) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  // Sample register: captured only on rd_done in WAIT, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             sample_data <= '0;
    else if ((state == S_WAIT) && rd_done) sample_data <= rd_data;
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM.
  // ---------------------------------------------------------------------------
  // State and grant registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= SRC_POLL;
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
    end
  end

  // Next-state, grant and strobe outputs.
  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = last_grant;
    rd_start     = 1'b0;
    sample_valid = 1'b0;
    host_ack     = 1'b0;
    sample_src   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (poll_pending || host_pending)) begin
          state_nxt = S_START;
          if (poll_pending && host_pending)
            grant_nxt = (last_grant == SRC_POLL) ? SRC_HOST : SRC_POLL;
          else
            grant_nxt = host_pending ? SRC_HOST : SRC_POLL;
        end
      end
      S_START: begin
        rd_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rd_done) begin
          state_nxt = S_DONE;
        end else if (to_fire) begin
          // Abort: the host still gets its completion handshake, without data.
          state_nxt  = S_IDLE;
          host_ack   = (last_grant == SRC_HOST);
          sample_src = last_grant;
        end
      end
      S_DONE: begin
        sample_valid = 1'b1;
        sample_src   = last_grant;
        host_ack     = (last_grant == SRC_HOST);
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SENSE_OVERRUN_CNT_EN
  // ---------------------------------------------------------------------------
  // Overrun counter: poll events that collapsed into a pending poll.
  // ---------------------------------------------------------------------------
  logic poll_drop;
  assign poll_drop = poll_event & poll_pending;

  // Saturating count; err_clr restarts it, keeping a same-cycle drop as 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overrun_cnt <= 8'd0;
    else if (err_clr)                        overrun_cnt <= poll_drop ? 8'd1 : 8'd0;
    else if (poll_drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sense_poll_scheduler.sv
// tb_sense_poll_scheduler: directed scenarios for sense_poll_scheduler with a
// small scoreboard of expected completions (data samples and host timeouts).
// Runs with DIV_COUNT=3, POLL_TICKS=4, TIMEOUT_TICKS=5 so every event lands
// on a known cycle counted from reset release.
`timescale 1ns/1ps

module tb_sense_poll_scheduler;

  localparam int DIV_COUNT     = 3;
  localparam int POLL_TICKS    = 4;
  localparam int TIMEOUT_TICKS = 5;
  localparam int DATA_W        = 16;

  typedef struct packed {
    logic              is_timeout;
    logic              src;
    logic              ack;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              host_req;
  logic              host_ack;
  logic              rd_start;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              tick_en;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_src;
  logic              timeout_err;
  logic              err_clr;
`ifdef SENSE_OVERRUN_CNT_EN
  logic [7:0]        overrun_cnt;
`endif

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  sense_poll_scheduler #(
    .DIV_COUNT    (DIV_COUNT),
    .POLL_TICKS   (POLL_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .DATA_W       (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .host_req    (host_req),
    .host_ack    (host_ack),
    .rd_start    (rd_start),
    .rd_done     (rd_done),
    .rd_data     (rd_data),
    .tick_en     (tick_en),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_src  (sample_src),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
`ifdef SENSE_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    cycle = cycle + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; host_req = 1'b0;
    rd_done = 1'b0; rd_data = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({host_ack, rd_start, tick_en, sample_valid, sample_src, timeout_err} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
                      {host_ack, rd_start, tick_en, sample_valid, sample_src, timeout_err});
    end
    total++; if (sample_data !== 16'h0000) begin
      bad++; $display("FAIL reset_sample_data: got %h want 0000", sample_data);
    end
`ifdef SENSE_OVERRUN_CNT_EN
    total++; if (overrun_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    cycle = 0;
  endtask

  // Tick every 4th clock from release; first poll read strobed at cycle 17.
  task automatic test_tick_and_poll();
    for (int c = 0; c <= 17; c++) begin
      if (c != 0) next_cycle();
      #1;
      total++; if (tick_en !== ((c % 4) == 3)) begin
        bad++; $display("FAIL tick_en cycle %0d: got %b want %b", c, tick_en, ((c % 4) == 3));
      end
      total++; if (rd_start !== (c == 17)) begin
        bad++; $display("FAIL poll_rd_start cycle %0d: got %b want %b", c, rd_start, (c == 17));
      end
    end
  endtask

  // rd_done three clocks after rd_start; sample one cycle later, then held.
  task automatic test_poll_sample();
    exp_t e;
    while (cycle < 19) begin
      next_cycle(); #1;
      total++; if (rd_start !== 1'b0) begin
        bad++; $display("FAIL wait_rd_start cycle %0d: got %b want 0", cycle, rd_start);
      end
    end
    next_cycle();
    rd_done = 1'b1; rd_data = 16'h1A2B;
    sb_q.push_back('{is_timeout: 1'b0, src: 1'b0, ack: 1'b0, data: 16'h1A2B});
    #1;
    total++; if (sample_valid !== 1'b0) begin
      bad++; $display("FAIL early_valid: got %b want 0", sample_valid);
    end
    next_cycle();
    rd_done = 1'b0; rd_data = 16'hFFFF;
    #1;
    total++; if (sample_valid !== 1'b1) begin
      bad++; $display("FAIL poll_valid cycle %0d: got %b want 1", cycle, sample_valid);
    end
    if (sb_q.size() == 0) begin
      total++; bad++; $display("FAIL poll_sb: got empty queue want one entry");
    end else begin
      e = sb_q.pop_front();
      total++; if ({sample_src, host_ack, sample_data} !== {e.src, e.ack, e.data}) begin
        bad++; $display("FAIL poll_result: got src=%b ack=%b data=%h want src=%b ack=%b data=%h",
                        sample_src, host_ack, sample_data, e.src, e.ack, e.data);
      end
    end
    // Idle stretch: data holds, a stray rd_done outside WAIT is ignored,
    // and no further read starts before the next poll.
    while (cycle < 31) begin
      next_cycle();
      rd_done = (cycle == 25); rd_data = 16'h5555;
      #1;
      total++; if ({sample_valid, rd_start, sample_data} !== {2'b00, 16'h1A2B}) begin
        bad++; $display("FAIL hold cycle %0d: got valid=%b start=%b data=%h want 0 0 1a2b",
                        cycle, sample_valid, rd_start, sample_data);
      end
    end
    rd_done = 1'b0;
  endtask

  // Host and poll pending together with last_grant=poll: host first, then poll.
  task automatic test_round_robin();
    exp_t e;
    next_cycle();  // cycle 32: poll_pending just became visible
    host_req = 1'b1;
    #1;
    next_cycle(); #1;  // 33
    total++; if (rd_start !== 1'b1) begin
      bad++; $display("FAIL rr_host_start cycle %0d: got %b want 1", cycle, rd_start);
    end
    next_cycle();  // 34
    next_cycle();  // 35
    rd_done = 1'b1; rd_data = 16'hBEEF;
    sb_q.push_back('{is_timeout: 1'b0, src: 1'b1, ack: 1'b1, data: 16'hBEEF});
    next_cycle();  // 36
    rd_done = 1'b0;
    #1;
    e = sb_q.pop_front();
    total++; if ({sample_valid, sample_src, host_ack, sample_data} !== {1'b1, e.src, e.ack, e.data}) begin
      bad++; $display("FAIL rr_first: got v=%b src=%b ack=%b data=%h want v=1 src=%b ack=%b data=%h",
                      sample_valid, sample_src, host_ack, sample_data, e.src, e.ack, e.data);
    end
    next_cycle();  // 37
    host_req = 1'b0;
    next_cycle(); #1;  // 38
    total++; if (rd_start !== 1'b1) begin
      bad++; $display("FAIL rr_poll_start cycle %0d: got %b want 1", cycle, rd_start);
    end
    next_cycle();  // 39
    next_cycle();  // 40
    rd_done = 1'b1; rd_data = 16'h0C0D;
    sb_q.push_back('{is_timeout: 1'b0, src: 1'b0, ack: 1'b0, data: 16'h0C0D});
    next_cycle();  // 41
    rd_done = 1'b0;
    #1;
    e = sb_q.pop_front();
    total++; if ({sample_valid, sample_src, host_ack, sample_data} !== {1'b1, e.src, e.ack, e.data}) begin
      bad++; $display("FAIL rr_second: got v=%b src=%b ack=%b data=%h want v=1 src=%b ack=%b data=%h",
                      sample_valid, sample_src, host_ack, sample_data, e.src, e.ack, e.data);
    end
  endtask

  // Host read never completes: abort after 5 ticks in WAIT, then err_clr.
  task automatic test_host_timeout();
    exp_t e;
    int   ticks;
    bit   seen;
    logic sv_at_ack;
    logic src_at_ack;
    next_cycle();
    host_req = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rd_start === 1'b1) seen = 1'b1;
      else begin next_cycle(); #1; end
    end
    total++; if (!seen) begin
      bad++; $display("FAIL to_start: got no rd_start want rd_start within 10 cycles");
    end
    sb_q.push_back('{is_timeout: 1'b1, src: 1'b1, ack: 1'b1, data: '0});
    ticks = 0; seen = 1'b0; sv_at_ack = 1'bx; src_at_ack = 1'bx;
    for (int i = 0; i < 40 && !seen; i++) begin
      next_cycle(); #1;
      if (tick_en === 1'b1) ticks++;
      if (host_ack === 1'b1) begin
        seen = 1'b1; sv_at_ack = sample_valid; src_at_ack = sample_src;
      end
    end
    total++; if (!seen) begin
      bad++; $display("FAIL to_ack: got no host_ack want host_ack within 40 cycles");
    end
    total++; if (ticks != TIMEOUT_TICKS) begin
      bad++; $display("FAIL to_ticks: got %0d want %0d", ticks, TIMEOUT_TICKS);
    end
    e = sb_q.pop_front();
    total++; if ({sv_at_ack, src_at_ack} !== {~e.is_timeout, e.src}) begin
      bad++; $display("FAIL to_ack_fields: got valid=%b src=%b want valid=%b src=%b",
                      sv_at_ack, src_at_ack, ~e.is_timeout, e.src);
    end
    next_cycle();
    host_req = 1'b0;
    #1;
    total++; if ({timeout_err, host_ack} !== 2'b10) begin
      bad++; $display("FAIL to_err_set: got err=%b ack=%b want err=1 ack=0", timeout_err, host_ack);
    end
    // The poll that arrived during the host read is served afterwards.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rd_start === 1'b1) seen = 1'b1;
      else begin next_cycle(); #1; end
    end
    total++; if (!seen) begin
      bad++; $display("FAIL to_poll_start: got no rd_start want rd_start within 20 cycles");
    end
    next_cycle();
    next_cycle();
    rd_done = 1'b1; rd_data = 16'h2468;
    sb_q.push_back('{is_timeout: 1'b0, src: 1'b0, ack: 1'b0, data: 16'h2468});
    next_cycle();
    rd_done = 1'b0;
    #1;
    e = sb_q.pop_front();
    total++; if ({sample_valid, sample_src, host_ack, sample_data} !== {1'b1, e.src, e.ack, e.data}) begin
      bad++; $display("FAIL to_poll_result: got v=%b src=%b ack=%b data=%h want v=1 src=%b ack=%b data=%h",
                      sample_valid, sample_src, host_ack, sample_data, e.src, e.ack, e.data);
    end
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    #1;
    total++; if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL err_clr: got %b want 0", timeout_err);
    end
  endtask

  // Reset two clocks into WAIT: outputs drop at once, late rd_done ignored.
  task automatic test_reset_mid_wait();
    bit seen;
    next_cycle();
    host_req = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rd_start === 1'b1) seen = 1'b1;
      else begin next_cycle(); #1; end
    end
    total++; if (!seen) begin
      bad++; $display("FAIL rst_start: got no rd_start want rd_start within 10 cycles");
    end
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1; host_req = 1'b0;
    #1;
    total++; if ({host_ack, rd_start, tick_en, sample_valid, sample_src, timeout_err, sample_data} !== '0) begin
      bad++; $display("FAIL rst_outputs: got ack=%b start=%b tick=%b v=%b src=%b err=%b data=%h want all 0",
                      host_ack, rd_start, tick_en, sample_valid, sample_src, timeout_err, sample_data);
    end
    next_cycle();
    reset = 1'b0;
    cycle = 0;
    while (cycle < 17) begin
      next_cycle();
      rd_done = (cycle == 1); rd_data = 16'h7777;
      #1;
      total++; if ({sample_valid, host_ack, rd_start} !== {2'b00, (cycle == 17)}) begin
        bad++; $display("FAIL rst_after cycle %0d: got v=%b ack=%b start=%b want 0 0 %b",
                        cycle, sample_valid, host_ack, rd_start, (cycle == 17));
      end
    end
    rd_done = 1'b0;
  endtask

  // Poll reads left unanswered: timeouts at 35/67/99, dropped polls at 31/63/95.
  task automatic test_poll_timeout();
    while (cycle < 96) begin
      next_cycle(); #1;
      total++; if ({rd_start, sample_valid, host_ack} !== {(cycle == 49 || cycle == 81), 2'b00}) begin
        bad++; $display("FAIL pto_strobes cycle %0d: got start=%b v=%b ack=%b want %b 0 0",
                        cycle, rd_start, sample_valid, host_ack, (cycle == 49 || cycle == 81));
      end
      if (cycle == 35 || cycle == 36) begin
        total++; if (timeout_err !== (cycle == 36)) begin
          bad++; $display("FAIL pto_err cycle %0d: got %b want %b", cycle, timeout_err, (cycle == 36));
        end
      end
`ifdef SENSE_OVERRUN_CNT_EN
      if (cycle == 31 || cycle == 32 || cycle == 64 || cycle == 96) begin
        total++; if (overrun_cnt !== ((cycle == 31) ? 8'd0 : (cycle == 32) ? 8'd1 :
                                      (cycle == 64) ? 8'd2 : 8'd3)) begin
          bad++; $display("FAIL overrun cycle %0d: got %0d", cycle, overrun_cnt);
        end
      end
`endif
    end
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    #1;
    total++; if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL pto_err_clr: got %b want 0", timeout_err);
    end
`ifdef SENSE_OVERRUN_CNT_EN
    total++; if (overrun_cnt !== 8'd0) begin
      bad++; $display("FAIL overrun_clr: got %0d want 0", overrun_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tick_and_poll();
    test_poll_sample();
    test_round_robin();
    test_host_timeout();
    test_reset_mid_wait();
    test_poll_timeout();
    total++; if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sense_poll_scheduler.md
Name: sense_poll_scheduler

Overview:
Sequences temperature-sensor reads on the Tempsens board. Generates the serial-rate clock enable (tick_en) by dividing clk; it does not produce a derived clock. Arbitrates between a periodic poll timer and host one-shot read requests, and issues one read transaction at a time to the serial reader. Handles reader completion, timeout and result delivery.

Parameters:
DIV_COUNT, 135000, tick_en period minus 1 in clk cycles (tick_en every DIV_COUNT+1 clocks)
POLL_TICKS, 270000, ticks between periodic poll requests (≥2)
TIMEOUT_TICKS, 64, ticks in WAIT without rd_done before abort (≥1)
DATA_W, 16, sensor sample width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  scheduler enable
host_req  in  1  host read request; level, held until host_ack
host_ack  out  1  one-cycle pulse: host request finished (data or timeout)
rd_start  out  1  one-cycle start strobe to serial reader
rd_done  in  1  one-cycle reader completion strobe, rd_data valid
rd_data  in  DATA_W  reader result
tick_en  out  1  one-cycle strobe every DIV_COUNT+1 clocks
sample_data  out  DATA_W  last captured sample
sample_valid  out  1  one-cycle strobe, sample_data updated
sample_src  out  1  0 = periodic poll, 1 = host; valid with sample_valid/host_ack
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears timeout_err (and overrun_cnt if built in)

Behaviour:
- Reset (async): all outputs 0, all counters 0, pending bits 0, last_grant = poll, FSM = IDLE. A transaction in flight is abandoned. No sample_valid or host_ack is issued for it after release.
- Divider: counts 0..DIV_COUNT and wraps to 0. tick_en=1 in exactly the cycle the counter equals DIV_COUNT. Runs regardless of enable.
- Poll timer: advances only on tick_en while enable=1; counts 0..POLL_TICKS-1 and wraps.
  - On the tick where it equals POLL_TICKS-1, poll_pending is set (registered, visible next cycle).
  - enable=0: poll timer held at 0 and poll_pending cleared.
- Host pending = host_req & enable & not already granted. host_req while enable=0 is ignored until enable returns.
- FSM states:
  - IDLE:
    - If enable=1 and any pending, go to START.
    - Grant rule: if both pending, grant the source opposite to last_grant (round-robin); otherwise grant the single pending source.
    - Record grant in last_grant.
  - START: rd_start=1 for this cycle only; timeout counter cleared; go to WAIT.
  - WAIT:
    - rd_done=1: capture rd_data, go to DONE.
    - Otherwise the timeout counter increments on each tick_en.
    - When the counter reaches TIMEOUT_TICKS: set timeout_err, clear the granted pending bit, pulse host_ack if the grant is host (sample_src=1, sample_valid=0), go to IDLE.
    - rd_done in the same cycle as the timeout limit: rd_done wins.
  - DONE:
    - sample_valid=1, sample_data = captured value, sample_src = grant.
    - host_ack=1 in the same cycle if the grant is host.
    - Clear the granted pending bit; go to IDLE.
- Latency:
  - Tick at cycle N sets poll_pending at N+1; rd_start is asserted at N+2 (if IDLE).
  - rd_done at cycle T gives sample_valid at T+1.
- Poll event while poll_pending is already set or being served: collapses into the existing pending bit (dropped). Set takes priority over clear in the same cycle.
- enable falling mid-transaction: the current transaction completes normally; no new grants are made.
- rd_done outside WAIT is ignored.
- timeout_err: set has priority over err_clr in the same cycle.
- sample_data holds its value between samples.

Optional Feature:
SENSE_OVERRUN_CNT_EN:
- Defined: adds output port overrun_cnt (8 bits, reset 0).
  - Increments once per dropped poll event (poll timer wrap while poll_pending=1).
  - Saturates at 255.
  - Cleared by err_clr; an increment in the same cycle as err_clr yields 1.
- Undefined: port and counter are absent; dropped polls are silently collapsed.

Test Plan:
1. DIV_COUNT=3, POLL_TICKS=4, enable=1 after reset -> tick_en high every 4th clock (cycles 3,7,11,15); rd_start single pulse at cycle 17; no other rd_start before cycle 33.
2. rd_done with rd_data=0x1A2B issued 3 clocks after rd_start -> next cycle sample_valid=1, sample_data=0x1A2B, sample_src=0, host_ack=0; sample_data holds 0x1A2B afterwards.
3. host_req and poll_pending both pending in IDLE with last_grant=poll -> host served first (sample_src=1 with host_ack=1), then poll served next (sample_src=0); last_grant ends as poll.
4. TIMEOUT_TICKS=5, host grant, rd_done never asserted -> after 5 tick_en in WAIT, timeout_err=1 and host_ack=1 with sample_valid=0, FSM returns to IDLE; err_clr pulse -> timeout_err=0.
5. reset asserted 2 clocks into WAIT, rd_done applied after release -> all outputs 0 immediately; no sample_valid until a fresh rd_start occurs.
6. SENSE_OVERRUN_CNT_EN, POLL_TICKS=2, rd_done withheld, TIMEOUT_TICKS=8 -> overrun_cnt=3 after 3 dropped poll wraps; err_clr -> 0.
